// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU op sequencer: op bit indices, FSM state codes, error codes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_ctrl_pkg;

  // Bit positions inside the one-hot ALU ctrl vector.
  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_MUL = 2;
  localparam int OP_DIV = 3;
  localparam int OP_SHR = 4;
  localparam int OP_SHL = 5;
  localparam int OP_ROR = 6;
  localparam int OP_ROL = 7;
  localparam int OP_AND = 8;
  localparam int OP_OR  = 9;
  localparam int OP_NEG = 10;
  localparam int OP_NOT = 11;

  // Sequencer FSM states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Response error codes.
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;

  // Which hold-time class an op belongs to.
  typedef enum logic [1:0] {
    LAT_ALU = 2'd0,
    LAT_MUL = 2'd1,
    LAT_DIV = 2'd2
  } lat_sel_e;

  // Counter width able to hold (max latency - 1); never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m <= 1) return 1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Classifies a requested op: legality (exactly one hot bit), divide-by-zero, hold-time class.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, only consumed on the accept edge.
// Ports: i_op (one-hot op), i_y (operand Y) -> o_legal, o_div_zero, o_lat_sel.
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
) (
  input  logic [SIG_COUNT-1:0] i_op,
  input  logic [BITS-1:0]      i_y,
  output logic                 o_legal,
  output logic                 o_div_zero,
  output lat_sel_e             o_lat_sel
);

  logic [SIG_COUNT-1:0] w_op_minus1;

  // x & (x-1) clears the lowest set bit, so it is zero only for 0 or one-hot x.
  assign w_op_minus1 = i_op - 1'b1;
  assign o_legal     = (i_op != '0) && ((i_op & w_op_minus1) == '0);
  assign o_div_zero  = o_legal && i_op[OP_DIV] && (i_y == '0);

  always_comb begin
    o_lat_sel = LAT_ALU;
    if (i_op[OP_MUL]) begin
      o_lat_sel = LAT_MUL;
    end else if (i_op[OP_DIV]) begin
      o_lat_sel = LAT_DIV;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one op at a time to a combinational ALU, holds its inputs for a per-op latency, returns the result.
// Latency: legal op -> rsp_valid L edges after accept (L = ALU/MUL/DIV_CYCLES); rejected op -> on the accept edge.
// Backpressure: req_ready only in IDLE; response is held frozen until rsp_ready, no back-to-back issue.
// Ports: clk/clr; req_valid/req_ready/req_op/req_x/req_y request; alu_ctrl/alu_x/alu_y/alu_result ALU side;
//        rsp_valid/rsp_ready/rsp_zhi/rsp_zlo/rsp_err response; busy status.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = 12,
  parameter int ALU_CYCLES = 1,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [SIG_COUNT-1:0] req_op,
  input  logic [BITS-1:0]      req_x,
  input  logic [BITS-1:0]      req_y,
  output logic [SIG_COUNT-1:0] alu_ctrl,
  output logic [BITS-1:0]      alu_x,
  output logic [BITS-1:0]      alu_y,
  input  logic [2*BITS-1:0]    alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BITS-1:0]      rsp_zhi,
  output logic [BITS-1:0]      rsp_zlo,
  output logic [1:0]           rsp_err,
  output logic                 busy
);

  localparam int CNT_W = cnt_width(ALU_CYCLES, MUL_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]           r_state;
  logic [SIG_COUNT-1:0] r_op;
  logic [BITS-1:0]      r_x;
  logic [BITS-1:0]      r_y;
  logic [CNT_W-1:0]     r_cnt;
  logic [BITS-1:0]      r_zhi;
  logic [BITS-1:0]      r_zlo;
  logic [1:0]           r_err;

  logic                 w_legal;
  logic                 w_div_zero;
  lat_sel_e             w_lat_sel;
  logic [CNT_W-1:0]     w_cnt_init;

  alu_op_decode #(
    .BITS      (BITS),
    .SIG_COUNT (SIG_COUNT)
  ) u_decode (
    .i_op       (req_op),
    .i_y        (req_y),
    .o_legal    (w_legal),
    .o_div_zero (w_div_zero),
    .o_lat_sel  (w_lat_sel)
  );

  // Counter starts at L-1 and the capture happens on the edge where it reads 0,
  // giving exactly L cycles of stable ALU inputs.
  always_comb begin
    w_cnt_init = ALU_LAST;
    case (w_lat_sel)
      LAT_MUL: w_cnt_init = MUL_LAST;
      LAT_DIV: w_cnt_init = DIV_LAST;
      default: w_cnt_init = ALU_LAST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_op    <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_zhi   <= '0;
      r_zlo   <= '0;
      r_err   <= ERR_OK;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op <= req_op;
            r_x  <= req_x;
            r_y  <= req_y;
            if (!w_legal) begin
              r_state <= ST_DONE;
              r_err   <= ERR_ILLEGAL;
              r_zhi   <= '0;
              r_zlo   <= '0;
            end else if (w_div_zero) begin
              r_state <= ST_DONE;
              r_err   <= ERR_DIV0;
              r_zhi   <= '0;
              r_zlo   <= '0;
            end else begin
              r_state <= ST_EXEC;
              r_err   <= ERR_OK;
              r_cnt   <= w_cnt_init;
            end
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_zhi   <= alu_result[2*BITS-1:BITS];
            r_zlo   <= alu_result[BITS-1:0];
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Ctrl is gated by state so the ALU only ever sees an op while it is being executed;
  // rejected ops are registered but never reach alu_ctrl.
  assign alu_ctrl  = (r_state == ST_EXEC) ? r_op : '0;
  assign alu_x     = r_x;
  assign alu_y     = r_y;
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_DONE);
  assign rsp_zhi   = r_zhi;
  assign rsp_zlo   = r_zlo;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU on the alu_* side.
// Latency: checks L-cycle hold and response timing per op class.
// Backpressure: holds rsp_ready low and drives a competing request.
module tb_alu_op_sequencer;

  logic        clk;
  logic        clr;
  logic        req_valid;
  logic        req_ready;
  logic [11:0] req_op;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [11:0] alu_ctrl;
  logic [31:0] alu_x;
  logic [31:0] alu_y;
  logic [63:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_zhi;
  logic [31:0] rsp_zlo;
  logic [1:0]  rsp_err;
  logic        busy;

  int n_checks;
  int n_fail;
  int alu_issue_cycles;

  alu_op_sequencer #(
    .BITS       (32),
    .SIG_COUNT  (12),
    .ALU_CYCLES (1),
    .MUL_CYCLES (4),
    .DIV_CYCLES (8)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .alu_ctrl   (alu_ctrl),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_zhi    (rsp_zhi),
    .rsp_zlo    (rsp_zlo),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: signed mul/div, quotient in lo and remainder in hi.
  logic signed [63:0] m_sx;
  logic signed [63:0] m_sy;
  logic signed [31:0] m_x32;
  logic signed [31:0] m_y32;
  always_comb begin
    m_sx  = {{32{alu_x[31]}}, alu_x};
    m_sy  = {{32{alu_y[31]}}, alu_y};
    m_x32 = alu_x;
    m_y32 = alu_y;
    alu_result = 64'h0;
    case (alu_ctrl)
      12'h001: alu_result = {32'h0, alu_x + alu_y};
      12'h002: alu_result = {32'h0, alu_x - alu_y};
      12'h004: alu_result = m_sx * m_sy;
      12'h008: if (alu_y != 32'h0) alu_result = {m_x32 % m_y32, m_x32 / m_y32};
      12'h100: alu_result = {32'h0, alu_x & alu_y};
      12'h200: alu_result = {32'h0, alu_x | alu_y};
      default: alu_result = 64'h0;
    endcase
  end

  // Counts cycles in which the ALU was handed a nonzero ctrl.
  always @(posedge clk) begin
    if (alu_ctrl != 12'h0) alu_issue_cycles <= alu_issue_cycles + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request for one accept edge, then withdraws it.
  task automatic issue(input logic [11:0] op, input logic [31:0] x, input logic [31:0] y);
    req_op    = op;
    req_x     = x;
    req_y     = y;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    int cyc;
    int snap;
    n_checks         = 0;
    n_fail           = 0;
    alu_issue_cycles = 0;
    clr       = 1'b1;
    req_valid = 1'b0;
    req_op    = 12'h0;
    req_x     = 32'h0;
    req_y     = 32'h0;
    rsp_ready = 1'b1;
    tick();
    tick();
    clr = 1'b0;

    // Reset state
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_alu_ctrl",  64'(alu_ctrl),  64'd0);
    check("rst_alu_xy",    {alu_x, alu_y}, 64'd0);
    check("rst_z",         {rsp_zhi, rsp_zlo}, 64'd0);
    check("rst_err",       64'(rsp_err),   64'd0);

    // add 15+5: one EXEC cycle, response on the next edge
    issue(12'h001, 32'd15, 32'd5);
    check("add_ctrl",      64'(alu_ctrl),  64'h001);
    check("add_x",         64'(alu_x),     64'd15);
    check("add_not_yet",   64'(rsp_valid), 64'd0);
    tick();
    check("add_valid",     64'(rsp_valid), 64'd1);
    check("add_z",         {rsp_zhi, rsp_zlo}, 64'd20);
    check("add_err",       64'(rsp_err),   64'd0);
    check("add_ctrl_off",  64'(alu_ctrl),  64'd0);
    tick();
    check("add_idle",      64'(req_ready), 64'd1);

    // mul -15*5: ctrl held for exactly 4 cycles
    issue(12'h004, 32'hFFFF_FFF1, 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("mul_ctrl_c%0d", i), 64'(alu_ctrl), 64'h004);
      check($sformatf("mul_wait_c%0d", i), 64'(rsp_valid), 64'd0);
      tick();
    end
    check("mul_valid",     64'(rsp_valid), 64'd1);
    check("mul_z",         {rsp_zhi, rsp_zlo}, 64'hFFFF_FFFF_FFFF_FFB5);
    check("mul_err",       64'(rsp_err),   64'd0);
    tick();

    // div 15/-5: 8-cycle hold
    issue(12'h008, 32'd15, 32'hFFFF_FFFB);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("div_latency",   64'(cyc),       64'd8);
    check("div_z",         {rsp_zhi, rsp_zlo}, 64'h0000_0000_FFFF_FFFD);
    check("div_err",       64'(rsp_err),   64'd0);
    tick();

    // div by zero: rejected on the accept edge, ALU never driven
    snap = alu_issue_cycles;
    issue(12'h008, 32'd15, 32'd0);
    check("dz_valid",      64'(rsp_valid), 64'd1);
    check("dz_err",        64'(rsp_err),   64'd2);
    check("dz_z",          {rsp_zhi, rsp_zlo}, 64'd0);
    tick();
    check("dz_no_issue",   64'(alu_issue_cycles - snap), 64'd0);

    // Illegal ops: zero and multi-hot
    snap = alu_issue_cycles;
    issue(12'h000, 32'd1, 32'd2);
    check("ill0_valid",    64'(rsp_valid), 64'd1);
    check("ill0_err",      64'(rsp_err),   64'd1);
    check("ill0_z",        {rsp_zhi, rsp_zlo}, 64'd0);
    tick();
    issue(12'h300, 32'd3, 32'd4);
    check("ill300_valid",  64'(rsp_valid), 64'd1);
    check("ill300_err",    64'(rsp_err),   64'd1);
    check("ill300_z",      {rsp_zhi, rsp_zlo}, 64'd0);
    tick();
    check("ill_no_issue",  64'(alu_issue_cycles - snap), 64'd0);

    // or: F0 | 0F
    issue(12'h200, 32'h0000_00F0, 32'h0000_000F);
    tick();
    check("or_z",          {rsp_zhi, rsp_zlo}, 64'h0000_00FF);
    tick();

    // Backpressure: response frozen, competing request ignored
    rsp_ready = 1'b0;
    issue(12'h001, 32'd7, 32'd9);
    tick();
    req_op    = 12'h004;
    req_x     = 32'd100;
    req_y     = 32'd100;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_c%0d", i), 64'(rsp_valid), 64'd1);
      check($sformatf("bp_z_c%0d", i),     {rsp_zhi, rsp_zlo}, 64'd16);
      check($sformatf("bp_rdy_c%0d", i),   64'(req_ready), 64'd0);
      check($sformatf("bp_ctrl_c%0d", i),  64'(alu_ctrl),  64'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_release",    64'(req_ready), 64'd1);
    check("bp_no_stray",   64'(alu_x),     64'd7);
    tick();
    check("bp_still_idle", 64'(busy),      64'd0);

    // Mid-op reset during div
    issue(12'h008, 32'd100, 32'd3);
    tick();
    tick();
    check("mr_busy",       64'(busy),      64'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("mr_ready",      64'(req_ready), 64'd1);
    check("mr_valid",      64'(rsp_valid), 64'd0);
    check("mr_ctrl",       64'(alu_ctrl),  64'd0);
    check("mr_alu_xy",     {alu_x, alu_y}, 64'd0);
    check("mr_z",          {rsp_zhi, rsp_zlo}, 64'd0);
    check("mr_err",        64'(rsp_err),   64'd0);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) cyc++;
      tick();
    end
    check("mr_no_rsp",     64'(cyc),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
